// File: rtl/tmds_gearbox_pkg.sv
// Shared constants and types for the 10:2 TMDS gearbox.
package tmds_gearbox_pkg;

    localparam int unsigned LANE_W = 2;
    localparam int unsigned PHASES = 5;
    localparam int unsigned WORD_W = LANE_W * PHASES;

    localparam logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100;

    typedef logic [2:0] phase_t;

    localparam phase_t LAST_PHASE = phase_t'(PHASES - 1);

endpackage

// File: rtl/tmds_gearbox_10to2_skid_buf.sv
// Two-entry symbol FIFO in front of the gearbox shifter.
// ready and empty are registered; head_c is the combinational read port.
module gearbox_skid_buf #(
    parameter int unsigned WORD_W = tmds_gearbox_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] head_c,
    output logic              empty,
    output logic              ready
);
    import tmds_gearbox_pkg::*;

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;

    // Occupancy after this edge's push/pop.
    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + 2'd1;
        end else if (pop && !push) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    // Pointers and status flags; ready is held low during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            empty  <= 1'b1;
            ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == 2'd0);
            ready <= (cnt_nxt != 2'd2);
        end
    end

    // Data storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/tmds_gearbox_10to2.sv
// 10:2 gearbox: serializes 10-bit symbols two bits per fast clock, LSB first.
// Optional build macro GEARBOX_UNDERRUN_CNT_EN adds a saturating underrun counter.
module tmds_gearbox_10to2 #(
    parameter int unsigned       LANE_W    = tmds_gearbox_pkg::LANE_W,
    parameter int unsigned       WORD_W    = LANE_W * tmds_gearbox_pkg::PHASES,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(tmds_gearbox_pkg::IDLE_WORD)
) (
    input  logic              hclkin,
    input  logic              resetn,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] dout,
    output logic              dout_valid,
    output logic              word_strobe,
    output logic              underrun,
    input  logic              underrun_clr
`ifdef GEARBOX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);
    import tmds_gearbox_pkg::*;

    phase_t            phase;
    logic [WORD_W-1:0] shreg;
    logic              started;

    logic              boundary_c;
    logic              xfer_c;
    logic              bypass_c;
    logic              push_c;
    logic              pop_c;
    logic              underrun_evt_c;
    logic [WORD_W-1:0] next_word_c;
    logic [WORD_W-1:0] buf_head_c;
    logic              buf_empty;

    gearbox_skid_buf #(
        .WORD_W (WORD_W)
    ) u_skid_buf (
        .clk    (hclkin),
        .rst_n  (resetn),
        .push   (push_c),
        .pop    (pop_c),
        .din    (in_word),
        .head_c (buf_head_c),
        .empty  (buf_empty),
        .ready  (in_ready)
    );

    // Boundary decisions; a symbol arriving on the boundary edge into an
    // empty buffer goes straight to the shifter instead of waiting a symbol.
    always_comb begin
        boundary_c     = (phase == LAST_PHASE);
        xfer_c         = in_valid && in_ready;
        bypass_c       = boundary_c && buf_empty && xfer_c;
        push_c         = xfer_c && !bypass_c;
        pop_c          = boundary_c && !buf_empty;
        underrun_evt_c = boundary_c && buf_empty && !xfer_c && started;
        next_word_c    = IDLE_WORD;
        if (!buf_empty) begin
            next_word_c = buf_head_c;
        end else if (xfer_c) begin
            next_word_c = in_word;
        end
    end

    // Phase counter, shifter, output pair and sticky underrun flag.
    always_ff @(posedge hclkin) begin
        if (!resetn) begin
            phase       <= '0;
            shreg       <= IDLE_WORD;
            dout        <= '0;
            dout_valid  <= 1'b0;
            word_strobe <= 1'b0;
            underrun    <= 1'b0;
            started     <= 1'b0;
        end else begin
            phase       <= boundary_c ? '0 : phase + phase_t'(1);
            shreg       <= boundary_c ? next_word_c : (shreg >> LANE_W);
            dout        <= shreg[LANE_W-1:0];
            dout_valid  <= 1'b1;
            word_strobe <= (phase == '0);
            if (xfer_c) begin
                started <= 1'b1;
            end
            if (underrun_evt_c) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef GEARBOX_UNDERRUN_CNT_EN
    // Saturating underrun event counter; a same-cycle clear still counts the new event.
    always_ff @(posedge hclkin) begin
        if (!resetn) begin
            underrun_cnt <= 16'd0;
        end else if (underrun_evt_c) begin
            if (underrun_clr) begin
                underrun_cnt <= 16'd1;
            end else if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end else if (underrun_clr) begin
            underrun_cnt <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_gearbox_10to2.sv
// Scoreboard bench for tmds_gearbox_10to2; expected symbols are queued by the
// stimulus and a negedge monitor checks every emitted bit pair and strobe.
module tb_tmds_gearbox_10to2;

    localparam logic [9:0] IDLE = 10'b1101010100;

    logic       hclkin = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] in_word = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] dout;
    logic       dout_valid;
    logic       word_strobe;
    logic       underrun;
    logic       underrun_clr = 1'b0;
`ifdef GEARBOX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ph = 0;
    logic [9:0] exp_sym [$];

    tmds_gearbox_10to2 dut (
`ifdef GEARBOX_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .hclkin       (hclkin),
        .resetn       (resetn),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .word_strobe  (word_strobe),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 hclkin = ~hclkin;

    // Bench's own view of the symbol phase of the current cycle.
    always @(posedge hclkin) begin
        if (!resetn) ph <= 0;
        else ph <= (ph == 4) ? 0 : ph + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops one expected symbol per strobe period.
    logic [9:0] cur_sh = '0;
    int  idx = 0;
    bit  have_cur = 1'b0;
    always @(negedge hclkin) begin
        if (dout_valid !== 1'b1) begin
            idx = 0;
        end else begin
            if (idx == 0) begin
                if (exp_sym.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    have_cur = 1'b0;
                    $display("FAIL stream_extra: got dout %b with no symbol expected at %0t", dout, $time);
                end else begin
                    cur_sh   = exp_sym.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                chk("dout_pair", 16'(dout), 16'(cur_sh[1:0]));
                chk("word_strobe", 16'(word_strobe), 16'(idx == 0));
                cur_sh = cur_sh >> 2;
            end
            idx = (idx == 4) ? 0 : idx + 1;
        end
    end

    task automatic wait_ph(input int p);
        int n = 0;
        @(negedge hclkin);
        while (ph != p && n < 10) begin
            @(negedge hclkin);
            n++;
        end
    endtask

    // One boundary: optionally offer a symbol on the phase-4 cycle.
    task automatic step_sym(input bit give, input logic [9:0] w, input bit clr);
        logic [9:0] exp_w;
        wait_ph(4);
        exp_w = IDLE;
        if (give) begin
            chk("boundary_ready", 16'(in_ready), 16'd1);
            in_word  = w;
            in_valid = 1'b1;
            exp_w    = w;
        end
        underrun_clr = clr;
        exp_sym.push_back(exp_w);
        @(posedge hclkin);
        #1;
        in_valid     = 1'b0;
        underrun_clr = 1'b0;
    endtask

    // Offer w with in_valid held until accepted (called at a negedge).
    task automatic send(input logic [9:0] w);
        int n = 0;
        in_word  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge hclkin);
            n++;
        end
        chk("send_accept", 16'(in_ready), 16'd1);
        @(posedge hclkin);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"}, 16'(dout), 16'd0);
        chk({tag, "_dout_valid"}, 16'(dout_valid), 16'd0);
        chk({tag, "_word_strobe"}, 16'(word_strobe), 16'd0);
        chk({tag, "_in_ready"}, 16'(in_ready), 16'd0);
        chk({tag, "_underrun"}, 16'(underrun), 16'd0);
    endtask

    task automatic release_reset();
        exp_sym.delete();
        exp_sym.push_back(IDLE);
        @(negedge hclkin);
        resetn = 1'b1;
        @(posedge hclkin);
        #1;
        chk("first_dout_valid", 16'(dout_valid), 16'd1);
        chk("first_word_strobe", 16'(word_strobe), 16'd1);
        chk("first_in_ready", 16'(in_ready), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, n_cmp %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge hclkin);
        #1;
        chk_reset_outputs("rst");
`ifdef GEARBOX_UNDERRUN_CNT_EN
        chk("rst_cnt", underrun_cnt, 16'd0);
`endif

        // Idle stream before any symbol: no underrun
        release_reset();
        step_sym(1'b0, '0, 1'b0);
        step_sym(1'b0, '0, 1'b0);
        chk("idle_no_underrun", 16'(underrun), 16'd0);

        // Single symbol on the boundary cycle, then an underrun boundary
        step_sym(1'b1, 10'h2A5, 1'b0);
        chk("single_underrun0", 16'(underrun), 16'd0);
        step_sym(1'b0, '0, 1'b0);
        chk("single_underrun1", 16'(underrun), 16'd1);
`ifdef GEARBOX_UNDERRUN_CNT_EN
        chk("single_cnt", underrun_cnt, 16'd1);
`endif

        // Clear on a non-boundary cycle
        @(negedge hclkin);
        underrun_clr = 1'b1;
        @(posedge hclkin);
        #1;
        underrun_clr = 1'b0;
        chk("clr_underrun", 16'(underrun), 16'd0);
`ifdef GEARBOX_UNDERRUN_CNT_EN
        chk("clr_cnt", underrun_cnt, 16'd0);
`endif

        // Back-to-back symbols with in_valid held high
        exp_sym.push_back(10'h3FF);
        exp_sym.push_back(10'h000);
        exp_sym.push_back(10'h155);
        wait_ph(1);
        send(10'h3FF);
        @(negedge hclkin);
        send(10'h000);
        chk("b2b_full_ready", 16'(in_ready), 16'd0);
        @(negedge hclkin);
        send(10'h155);
        chk("b2b_full_again", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        wait_ph(4);
        @(posedge hclkin);
        wait_ph(4);
        @(posedge hclkin);
        #1;
        chk("b2b_no_underrun", 16'(underrun), 16'd0);
        chk("b2b_drained_ready", 16'(in_ready), 16'd1);

        // Three starved boundaries
        step_sym(1'b0, '0, 1'b0);
        step_sym(1'b0, '0, 1'b0);
        step_sym(1'b0, '0, 1'b0);
        chk("starve_underrun", 16'(underrun), 16'd1);
`ifdef GEARBOX_UNDERRUN_CNT_EN
        chk("starve_cnt", underrun_cnt, 16'd3);
`endif

        // Clear coinciding with an underrun event: set wins
        step_sym(1'b0, '0, 1'b1);
        chk("clr_vs_set_underrun", 16'(underrun), 16'd1);
`ifdef GEARBOX_UNDERRUN_CNT_EN
        chk("clr_vs_set_cnt", underrun_cnt, 16'd1);
`endif

        // Reset in phase 2 of 10'h1C3 with two symbols buffered
        step_sym(1'b1, 10'h1C3, 1'b0);
        @(negedge hclkin);
        send(10'h0F0);
        @(negedge hclkin);
        send(10'h30C);
        chk("mid_full_ready", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        wait_ph(2);
        resetn = 1'b0;
        @(posedge hclkin);
        #1;
        chk_reset_outputs("midrst");
        @(posedge hclkin);
        #1;
        release_reset();
        step_sym(1'b0, '0, 1'b0);
        step_sym(1'b0, '0, 1'b0);
        chk("post_rst_underrun", 16'(underrun), 16'd0);

        // Let the last queued symbol drain through the monitor
        repeat (5) @(negedge hclkin);
        #1;
        chk("queue_drained", 16'(exp_sym.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
